// File: rtl/core_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : core_pkg                                                   |
// | Description : Shared encodings for the RISC-V core pipeline: opcodes,    |
// |               ALU control, immediate format and result-source selects,   |
// |               plus the ID/EX pipeline-register bundle.                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package core_pkg;

  // Opcodes of the supported instruction subset
  localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OP_STORE  = 7'b0100011;
  localparam logic [6:0] C_OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] C_OP_IALU   = 7'b0010011;
  localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] C_OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  // Main-decoder to ALU-decoder hint
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  // Control bits carried into the execute stage
  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src;
    result_src_e result_src;
    alu_ctrl_e   alu_control;
  } ex_ctrl_t;

  // Full ID/EX pipeline-register contents
  typedef struct packed {
    ex_ctrl_t    ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm_ext;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } idex_t;

  // Sign-extended immediate for each instruction format; bit 31 is the sign
  function automatic logic [31:0] extend_imm(input logic [31:7] instr,
                                             input imm_src_e    src);
    logic [31:0] imm;
    case (src)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : reg_file                                                   |
// | Description : 32x32 architectural register file, two asynchronous read   |
// |               ports and one synchronous write port. x0 is hard-wired to  |
// |               zero; a same-cycle write is forwarded to the read ports.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module reg_file
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic        w_wr_en;

  // A write to x0 is discarded so x0 never holds anything but zero
  assign w_wr_en = we && (waddr != 5'd0);

  // Next-state of the array: only the addressed entry changes
  always_comb begin
    regs_d = regs_q;
    if (w_wr_en) begin
      regs_d[waddr] = wdata;
    end
  end

  // Storage; reset wins over any writeback presented on the same edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports with x0 forced to zero and writeback forwarded through
  always_comb begin
    rdata1 = regs_q[raddr1];
    rdata2 = regs_q[raddr2];
    if (raddr1 == 5'd0) begin
      rdata1 = '0;
    end else if (w_wr_en && (raddr1 == waddr)) begin
      rdata1 = wdata;
    end
    if (raddr2 == 5'd0) begin
      rdata2 = '0;
    end else if (w_wr_en && (raddr2 == waddr)) begin
      rdata2 = wdata;
    end
  end

endmodule
`default_nettype wire

// File: rtl/decode_cycle.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : decode_cycle                                               |
// | Description : Instruction-decode stage. Decodes InstrD, reads the        |
// |               register file, extends the immediate and captures all      |
// |               results into the ID/EX pipeline register.                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module decode_cycle
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  input  logic        FlushE,
  output logic [4:0]  Rs1D,
  output logic [4:0]  Rs2D,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        JumpE,
  output logic        BranchE,
  output logic        ALUSrcE,
  output logic [1:0]  ResultSrcE,
  output logic [2:0]  ALUControlE,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmExtE,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E,
  output logic [4:0]  RdE,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E
);

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic        w_funct7_5;
  logic [4:0]  w_rd;
  ex_ctrl_t    w_ctrl;
  imm_src_e    w_imm_src;
  alu_op_e     w_alu_op;
  alu_ctrl_e   w_alu_control;
  logic [31:0] w_rd1;
  logic [31:0] w_rd2;
  logic [31:0] w_imm_ext;
  idex_t       idex_d;
  idex_t       idex_q;

  assign w_opcode   = InstrD[6:0];
  assign w_funct3   = InstrD[14:12];
  assign w_funct7_5 = InstrD[30];
  assign w_rd       = InstrD[11:7];

  // Source indices go straight to the hazard unit, no register
  assign Rs1D = InstrD[19:15];
  assign Rs2D = InstrD[24:20];

  reg_file u_reg_file (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (Rs1D),
    .raddr2 (Rs2D),
    .rdata1 (w_rd1),
    .rdata2 (w_rd2),
    .we     (RegWriteW),
    .waddr  (RdW),
    .wdata  (ResultW)
  );

  // Main decoder; an unrecognised opcode leaves every control at zero (bubble)
  always_comb begin
    w_ctrl    = '0;
    w_imm_src = IMM_I;
    w_alu_op  = ALUOP_ADD;
    case (w_opcode)
      C_OP_LOAD: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.alu_src    = 1'b1;
        w_ctrl.result_src = RES_MEM;
      end
      C_OP_STORE: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_imm_src        = IMM_S;
      end
      C_OP_RTYPE: begin
        w_ctrl.reg_write = 1'b1;
        w_alu_op         = ALUOP_FUNCT;
      end
      C_OP_IALU: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_alu_op         = ALUOP_FUNCT;
      end
      C_OP_BRANCH: begin
        w_ctrl.branch = 1'b1;
        w_imm_src     = IMM_B;
        w_alu_op      = ALUOP_SUB;
      end
      C_OP_JAL: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.jump       = 1'b1;
        w_ctrl.result_src = RES_PC4;
        w_imm_src         = IMM_J;
      end
      default: begin
        w_ctrl = '0;
      end
    endcase
    w_ctrl.alu_control = w_alu_control;
  end

  // ALU decoder; sub needs opcode bit 5 so addi with imm[10]=1 stays add
  always_comb begin
    w_alu_control = ALU_ADD;
    case (w_alu_op)
      ALUOP_SUB: w_alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (w_funct3)
          3'b000:  w_alu_control = (w_opcode[5] && w_funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  w_alu_control = ALU_SLT;
          3'b110:  w_alu_control = ALU_OR;
          3'b111:  w_alu_control = ALU_AND;
          default: w_alu_control = ALU_ADD;
        endcase
      end
      default: w_alu_control = ALU_ADD;
    endcase
  end

  assign w_imm_ext = extend_imm(InstrD[31:7], w_imm_src);

  // Next ID/EX contents; a flush replaces everything with an all-zero bubble
  always_comb begin
    idex_d = '0;
    if (!FlushE) begin
      idex_d.ctrl     = w_ctrl;
      idex_d.rd1      = w_rd1;
      idex_d.rd2      = w_rd2;
      idex_d.imm_ext  = w_imm_ext;
      idex_d.pc       = PCD;
      idex_d.pc_plus4 = PCPlus4D;
      idex_d.rd       = w_rd;
      idex_d.rs1      = Rs1D;
      idex_d.rs2      = Rs2D;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign RegWriteE   = idex_q.ctrl.reg_write;
  assign MemWriteE   = idex_q.ctrl.mem_write;
  assign JumpE       = idex_q.ctrl.jump;
  assign BranchE     = idex_q.ctrl.branch;
  assign ALUSrcE     = idex_q.ctrl.alu_src;
  assign ResultSrcE  = idex_q.ctrl.result_src;
  assign ALUControlE = idex_q.ctrl.alu_control;
  assign RD1E        = idex_q.rd1;
  assign RD2E        = idex_q.rd2;
  assign ImmExtE     = idex_q.imm_ext;
  assign PCE         = idex_q.pc;
  assign PCPlus4E    = idex_q.pc_plus4;
  assign RdE         = idex_q.rd;
  assign Rs1E        = idex_q.rs1;
  assign Rs2E        = idex_q.rs2;

endmodule
`default_nettype wire
